// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a first-word fall-through RX FIFO.
// Optional parity checking is enabled with `define UART_RX_PARITY_EN (adds the PARITY state and the parity_err port).
module uart_rx #(
  parameter int unsigned DEPTH      = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] freq_divider,
  input  logic       rx_bit,
  input  logic       pop,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       clear_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK
  } state_t;

  logic       rx_meta, rx_s;
  logic [7:0] div_cnt;
  logic       tick;

  state_t     state, state_n;
  logic [3:0] s_cnt, s_cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n;
  logic       push, set_frame;
`ifdef UART_RX_PARITY_EN
  logic       par_bad, par_bad_n, set_parity;
`endif

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // Lowering freq_divider below div_cnt must still fire a tick, hence >=.
  assign tick = (div_cnt >= freq_divider);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      div_cnt <= '0;
    end else begin
      rx_meta <= rx_bit;
      rx_s    <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      s_cnt   <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      s_cnt   <= s_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n  = par_bad;
    set_parity = 1'b0;
`endif
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_n = S_START;
            s_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_n = 1'b0;
`endif
          end
        end
        S_START: begin
          if (s_cnt == 4'd7) begin
            s_cnt_n   = '0;
            bit_idx_n = '0;
            state_n   = rx_s ? S_IDLE : S_DATA;
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
        S_DATA: begin
          // 4-bit s_cnt wraps to 0 after 15, restarting the next bit period.
          s_cnt_n = s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            shift_n   = {rx_s, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = S_PARITY;
`else
              state_n = S_STOP;
`endif
              s_cnt_n = '0;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (s_cnt == 4'd15) begin
            if (rx_s != ((^shift) ^ PARITY_ODD)) begin
              set_parity = 1'b1;
              par_bad_n  = 1'b1;
            end
            state_n = S_STOP;
            s_cnt_n = '0;
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (s_cnt == 4'd15) begin
            s_cnt_n = '0;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad;
`else
              push = 1'b1;
`endif
              state_n = S_IDLE;
            end else begin
              set_frame = 1'b1;
              state_n   = S_BRK;
            end
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
        S_BRK: begin
          if (rx_s) begin
            state_n = S_IDLE;
            s_cnt_n = '0;
          end
        end
        default: begin
          state_n = S_IDLE;
          s_cnt_n = '0;
        end
      endcase
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign data_out = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= set_frame | (frame_err & ~clear_err);
      overrun   <= (push & full & ~pop) | (overrun & ~clear_err);
`ifdef UART_RX_PARITY_EN
      parity_err <= set_parity | (parity_err & ~clear_err);
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and a randomized run
// against a queue-based FIFO model. Honours UART_RX_PARITY_EN when defined.
module tb_uart_rx;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, rx_bit, pop, clear_err;
  logic [7:0] freq_divider, data_out;
  logic       empty, full, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  uart_rx #(.DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .freq_divider(freq_divider), .rx_bit(rx_bit), .pop(pop),
    .data_out(data_out), .empty(empty), .full(full), .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned bt       = 16;

  typedef struct {
    logic [7:0] fd;
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_div(input logic [7:0] d);
    freq_divider = d;
    bt = 16 * (int'(d) + 1);
  endtask

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(par);
`endif
    bits.push_back(stop);
    foreach (bits[k]) begin
      rx_bit = bits[k];
      wait_clks(bt);
    end
  endtask

  task automatic line_idle(input int unsigned nbits);
    rx_bit = 1'b1;
    wait_clks(nbits * bt);
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk);
    #1 clear_err = 1'b0;
  endtask

  task automatic expect_byte(input string name, input logic [7:0] b);
    @(negedge clk);
    check({name, " empty"}, empty, 1'b0);
    check({name, " data"}, data_out, b);
    do_pop();
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [10:0] fr;
    int unsigned sc;
    logic [7:0]  q[$];
    logic        exp_ovr;
    logic [7:0]  b;

    vecs = '{
      '{8'd0, 8'h55, 1'b1, 1'b1, 1'b0},
      '{8'd1, 8'hAA, 1'b1, 1'b1, 1'b0},
      '{8'd2, 8'h81, 1'b1, 1'b1, 1'b0},
      '{8'd0, 8'h7E, 1'b0, 1'b0, 1'b1},
      '{8'd3, 8'h01, 1'b1, 1'b1, 1'b0},
      '{8'd1, 8'hC3, 1'b0, 1'b0, 1'b1}
    };

    reset = 1'b1; rx_bit = 1'b1; pop = 1'b0; clear_err = 1'b0;
    set_div(8'd0);
    wait_clks(3);
    reset = 1'b0;
    @(negedge clk);
    check("reset empty", empty, 1'b1);
    check("reset full", full, 1'b0);
    check("reset data_out", data_out, 8'h00);
    check("reset frame_err", frame_err, 1'b0);
    check("reset overrun", overrun, 1'b0);

    // Vector table
    foreach (vecs[i]) begin
      set_div(vecs[i].fd);
      line_idle(2);
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data);
      line_idle(2);
      @(negedge clk);
      check($sformatf("vec%0d empty", i), empty, !vecs[i].exp_push);
      check($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_frame);
      if (vecs[i].exp_push) expect_byte($sformatf("vec%0d", i), vecs[i].data);
      pulse_clear();
      @(negedge clk);
      check($sformatf("vec%0d cleared", i), frame_err, 1'b0);
    end

    // Push latency at freq_divider=0: stop sample tick is the cycle after posedge sc
    set_div(8'd0);
    line_idle(2);
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = 8'h55;
    sc = 154 + 16 * (NB - 10);
    @(posedge clk);
    #1 rx_bit = fr[0];
    for (int unsigned c = 1; c <= 16 * NB; c++) begin
      @(posedge clk);
      if ((c % 16) == 0 && (c / 16) < NB) begin
        #1 rx_bit = fr[c/16];
      end
      @(negedge clk);
      if (c == sc) check("latency empty before", empty, 1'b1);
      if (c == sc + 1) begin
        check("latency empty after", empty, 1'b0);
        check("latency data", data_out, 8'h55);
        check("latency frame_err", frame_err, 1'b0);
        check("latency overrun", overrun, 1'b0);
      end
    end
    rx_bit = 1'b1;
    do_pop();

    // Start-bit glitch rejection
    set_div(8'd6);
    line_idle(2);
    rx_bit = 1'b0;
    wait_clks(4 * 7);
    line_idle(2);
    @(negedge clk);
    check("glitch no push", empty, 1'b1);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    line_idle(1);
    expect_byte("after glitch", 8'hA3);

    // Stop bit low followed by a long break
    set_div(8'd0);
    line_idle(2);
    send_frame(8'h00, 1'b0, 1'b0);
    wait_clks(20 * bt);
    @(negedge clk);
    check("break frame_err", frame_err, 1'b1);
    check("break no push", empty, 1'b1);
    pulse_clear();
    wait_clks(20 * bt);
    @(negedge clk);
    check("break single frame_err", frame_err, 1'b0);
    check("break still no push", empty, 1'b1);
    line_idle(2);
    pulse_clear();
    send_frame(8'h0F, 1'b1, ^8'h0F);
    line_idle(1);
    @(negedge clk);
    check("post-break frame_err", frame_err, 1'b0);
    expect_byte("post-break", 8'h0F);

    // Fill, overrun, drain
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, ^b);
      line_idle(1);
    end
    @(negedge clk);
    check("fill full", full, 1'b1);
    check("fill no overrun", overrun, 1'b0);
    send_frame(8'h10, 1'b1, ^8'h10);
    line_idle(1);
    @(negedge clk);
    check("overrun set", overrun, 1'b1);
    check("overrun still full", full, 1'b1);
    for (int i = 0; i < 16; i++) expect_byte($sformatf("drain%0d", i), 8'(i));
    @(negedge clk);
    check("drain empty", empty, 1'b1);
    check("drain not full", full, 1'b0);
    do_pop();
    @(negedge clk);
    check("pop when empty ignored", empty, 1'b1);
    pulse_clear();
    @(negedge clk);
    check("overrun cleared", overrun, 1'b0);

    // Reset in the middle of DATA
    send_frame(8'h77, 1'b1, ^8'h77);
    line_idle(1);
    @(negedge clk);
    check("pre-reset stored", empty, 1'b0);
    rx_bit = 1'b0; wait_clks(bt);
    rx_bit = 1'b1; wait_clks(bt);
    rx_bit = 1'b0; wait_clks(bt);
    rx_bit = 1'b1; wait_clks(bt);
    reset = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    @(negedge clk);
    check("midreset empty", empty, 1'b1);
    check("midreset full", full, 1'b0);
    check("midreset data_out", data_out, 8'h00);
    check("midreset frame_err", frame_err, 1'b0);
    check("midreset overrun", overrun, 1'b0);
    line_idle(2);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    line_idle(1);
    expect_byte("after reset", 8'h3C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    line_idle(1);
    send_frame(8'h03, 1'b1, 1'b1);
    line_idle(1);
    @(negedge clk);
    check("parity err set", parity_err, 1'b1);
    expect_byte("parity good byte", 8'h03);
    @(negedge clk);
    check("parity bad byte dropped", empty, 1'b1);
    pulse_clear();
    @(negedge clk);
    check("parity err cleared", parity_err, 1'b0);
`endif

    // Randomized traffic against a queue model
    exp_ovr = 1'b0;
    for (int n = 0; n < 28; n++) begin
      set_div(8'($urandom_range(0, 2)));
      line_idle(1);
      b = 8'($urandom);
      send_frame(b, 1'b1, ^b);
      line_idle(1);
      if (q.size() == DEPTH) exp_ovr = 1'b1;
      else q.push_back(b);
      @(negedge clk);
      check($sformatf("rand%0d full", n), full, q.size() == DEPTH);
      check($sformatf("rand%0d empty", n), empty, q.size() == 0);
      check($sformatf("rand%0d overrun", n), overrun, exp_ovr);
      if ($urandom_range(0, 3) == 0 && q.size() > 0) expect_byte($sformatf("rand%0d pop", n), q.pop_front());
    end
    while (q.size() > 0) expect_byte("rand drain", q.pop_front());
    @(negedge clk);
    check("rand final empty", empty, 1'b1);
    check("rand frame_err", frame_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
